// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S bus-master transmitter with a one-frame holding buffer.
// Optional macro I2S_TX_UNDERRUN_HOLD_EN: an underrun re-sends the last latched frame instead of silence.
module i2s_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int BCLK_HALF    = 16
) (
  input  logic                      audio_clk,
  input  logic                      rst_in,
  input  logic [2*SAMPLE_WIDTH-1:0] audio_in,
  input  logic                      audio_valid_in,
  output logic                      audio_ready_out,
  output logic                      i2s_clk,
  output logic                      lrcl_clk,
  output logic                      dac_data,
  output logic                      frame_start_out,
  output logic                      underrun_out
);

  localparam int DW = $clog2(BCLK_HALF);

  logic [DW-1:0]             div_q;
  logic                      bclk_q;
  logic [5:0]                bit_cnt_q;
  logic                      lrcl_q;
  logic                      dac_q;
  logic [63:0]               frame_q;
  logic [2*SAMPLE_WIDTH-1:0] buf_q;
  logic                      full_q;
  logic                      fs_q;
  logic                      ur_q;

  logic        div_tc;
  logic        fall;
  logic        latch;
  logic        accept;
  logic [5:0]  bit_cnt_d;
  logic [5:0]  bit_idx;
  logic [31:0] left_slot;
  logic [31:0] right_slot;
  logic [63:0] buf_frame;
  logic [63:0] uf_frame;

  always_comb begin
    div_tc     = (div_q == DW'(BCLK_HALF - 1));
    fall       = div_tc && bclk_q;
    bit_cnt_d  = bit_cnt_q + 6'd1;
    // Slot k carries F[64-k]; k=0 wraps to index 0, which still holds the old frame's LSB.
    bit_idx    = 6'd0 - bit_cnt_d;
    latch      = fall && (bit_cnt_q == 6'd63);
    accept     = audio_valid_in && !full_q;
    left_slot  = 32'(buf_q[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH]) << (32 - SAMPLE_WIDTH);
    right_slot = 32'(buf_q[SAMPLE_WIDTH-1:0]) << (32 - SAMPLE_WIDTH);
    buf_frame  = {left_slot, right_slot};
  end

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  assign uf_frame = frame_q;
`else
  assign uf_frame = '0;
`endif

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      div_q     <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= 6'd63;
      lrcl_q    <= 1'b1;
      dac_q     <= 1'b0;
      frame_q   <= '0;
      buf_q     <= '0;
      full_q    <= 1'b0;
      fs_q      <= 1'b0;
      ur_q      <= 1'b0;
    end else begin
      div_q <= div_tc ? '0 : div_q + DW'(1);
      if (div_tc) bclk_q <= !bclk_q;
      if (fall) begin
        bit_cnt_q <= bit_cnt_d;
        lrcl_q    <= bit_cnt_d[5];
        dac_q     <= frame_q[bit_idx];
      end
      fs_q <= latch;
      ur_q <= latch && !full_q;
      if (latch) begin
        if (full_q) begin
          frame_q <= buf_frame;
          full_q  <= 1'b0;
        end else begin
          frame_q <= uf_frame;
        end
      end
      // A same-cycle accept only happens with full_q low, so it never collides with the clear above.
      if (accept) begin
        buf_q  <= audio_in;
        full_q <= 1'b1;
      end
    end
  end

  assign audio_ready_out = !full_q;
  assign i2s_clk         = bclk_q;
  assign lrcl_clk        = lrcl_q;
  assign dac_data        = dac_q;
  assign frame_start_out = fs_q;
  assign underrun_out    = ur_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed self-checking bench for i2s_tx (SAMPLE_WIDTH=24, BCLK_HALF=2).
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_in;
  logic [47:0] audio_in;
  logic        audio_valid_in;
  logic        audio_ready_out;
  logic        i2s_clk, lrcl_clk, dac_data, frame_start_out, underrun_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ur_cnt = 0;
  int latch_cyc = 0;
  logic [63:0] frames[$];

  i2s_tx #(.SAMPLE_WIDTH(24), .BCLK_HALF(2)) dut (
    .audio_clk(clk), .rst_in(rst_in), .audio_in(audio_in),
    .audio_valid_in(audio_valid_in), .audio_ready_out(audio_ready_out),
    .i2s_clk(i2s_clk), .lrcl_clk(lrcl_clk), .dac_data(dac_data),
    .frame_start_out(frame_start_out), .underrun_out(underrun_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc = rst_in ? 0 : cyc + 1;

  // Serial monitor: rebuild each 64-bit frame from dac_data at BCLK rising edges.
  int          mk = 0;
  logic        mhave = 1'b0;
  logic        mprev = 1'b0;
  logic [63:0] mcur = '0;
  always @(posedge clk) begin
    #2;
    if (rst_in) begin
      mk = 0; mhave = 1'b0; mprev = 1'b0; mcur = '0;
    end else begin
      if (frame_start_out) latch_cyc = cyc;
      if (underrun_out) ur_cnt++;
      if (mprev && !i2s_clk) begin
        mk = frame_start_out ? 0 : mk + 1;
        if (mk == 0) check("lrcl_slot0", lrcl_clk, 1'b0);
        if (mk == 32) check("lrcl_slot32", lrcl_clk, 1'b1);
      end else if (!mprev && i2s_clk) begin
        if (mk >= 1) begin
          mcur[64-mk] = dac_data;
          mhave = 1'b1;
        end else if (mhave) begin
          mcur[0] = dac_data;
          frames.push_back(mcur);
          mcur = '0;
        end
      end
      mprev = i2s_clk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    int n = 0;
    while (cyc < c && n < 5000) begin tick(); n++; end
    check("run_to", 64'(cyc), 64'(c));
  endtask

  task automatic push(input logic [47:0] d, output int acc);
    int n = 0;
    audio_in = d;
    audio_valid_in = 1'b1;
    while (!audio_ready_out && n < 2000) begin tick(); n++; end
    check("push_ready", audio_ready_out, 1'b1);
    tick();
    acc = cyc;
    audio_valid_in = 1'b0;
  endtask

  task automatic wait_frames(input int cnt);
    int n = 0;
    while (frames.size() < cnt && n < 2000) begin tick(); n++; end
    check("frame_count", 64'(frames.size() >= cnt), 64'd1);
  endtask

  localparam logic [63:0] F_1 = 64'hABCDEF00_12345600;
  localparam logic [63:0] F_A = 64'h80000100_FFFFFF00;
  localparam logic [63:0] F_B = 64'h00000100_7FFFFF00;
  localparam logic [63:0] F_C = 64'h13579B00_2468AC00;
  localparam logic [63:0] F_D = 64'hDEAD0100_BEEF0200;
  localparam logic [63:0] F_G = 64'hC0FFEE00_0BADF000;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  localparam logic [63:0] F_U = F_C;
`else
  localparam logic [63:0] F_U = 64'h0;
`endif

  initial begin
    int acc;
    int ur0;
    rst_in = 1'b1;
    audio_valid_in = 1'b0;
    audio_in = '0;
    repeat (3) tick();
    check("rst_bclk", i2s_clk, 1'b0);
    check("rst_lrcl", lrcl_clk, 1'b1);
    check("rst_dac", dac_data, 1'b0);
    check("rst_ready", audio_ready_out, 1'b1);
    check("rst_fs", frame_start_out, 1'b0);
    check("rst_ur", underrun_out, 1'b0);

    rst_in = 1'b0;
    tick();
    check("bclk_c1", i2s_clk, 1'b0);
    audio_in = {24'hABCDEF, 24'h123456};
    audio_valid_in = 1'b1;
    tick();
    audio_valid_in = 1'b0;
    check("bclk_c2", i2s_clk, 1'b1);
    check("ready_c2", audio_ready_out, 1'b0);
    tick();
    tick();
    check("bclk_c4", i2s_clk, 1'b0);
    check("lrcl_c4", lrcl_clk, 1'b0);
    check("fs_c4", frame_start_out, 1'b1);
    check("ur_c4", underrun_out, 1'b0);
    tick();
    check("fs_c5", frame_start_out, 1'b0);
    check("ready_c5", audio_ready_out, 1'b1);
    run_to(131);
    check("lrcl_c131", lrcl_clk, 1'b0);
    tick();
    check("lrcl_c132", lrcl_clk, 1'b1);

    // Backpressure: valid held through A, B, C
    push({24'h800001, 24'hFFFFFF}, acc);
    check("acc_a", 64'(acc), 64'd133);
    check("rdy_after_a", audio_ready_out, 1'b0);
    push({24'h000001, 24'h7FFFFF}, acc);
    check("acc_b", 64'(acc), 64'd261);
    check("acc_b_latch", 64'(acc), 64'(latch_cyc + 1));
    push({24'h13579B, 24'h2468AC}, acc);
    check("acc_c", 64'(acc), 64'd517);
    ur0 = ur_cnt;

    run_to(1541);
    check("ur_three", 64'(ur_cnt - ur0), 64'd3);

    // Same-cycle accept and latch with the buffer empty
    run_to(1795);
    audio_in = {24'hDEAD01, 24'hBEEF02};
    audio_valid_in = 1'b1;
    tick();
    audio_valid_in = 1'b0;
    check("sc_fs", frame_start_out, 1'b1);
    check("sc_ur", underrun_out, 1'b1);
    check("sc_ready", audio_ready_out, 1'b0);

    run_to(2053);
    push({24'h111111, 24'h222222}, acc);
    run_to(2309);
    push({24'h333333, 24'h444444}, acc);
    wait_frames(9);
    check("frame0", frames[0], F_1);
    check("frame1_a", frames[1], F_A);
    check("frame2_b", frames[2], F_B);
    check("frame3_c", frames[3], F_C);
    check("frame4_u", frames[4], F_U);
    check("frame5_u", frames[5], F_U);
    check("frame6_u", frames[6], F_U);
    check("frame7_u", frames[7], F_U);
    check("frame8_d", frames[8], F_D);

    // Mid-frame reset during bit_cnt=40 of the E frame
    run_to(2468);
    check("pre_rst_lrcl", lrcl_clk, 1'b1);
    check("pre_rst_ready", audio_ready_out, 1'b0);
    rst_in = 1'b1;
    tick();
    check("mrst_bclk", i2s_clk, 1'b0);
    check("mrst_lrcl", lrcl_clk, 1'b1);
    check("mrst_dac", dac_data, 1'b0);
    check("mrst_ready", audio_ready_out, 1'b1);
    check("mrst_fs", frame_start_out, 1'b0);
    check("mrst_ur", underrun_out, 1'b0);
    tick();
    rst_in = 1'b0;
    tick();
    audio_in = {24'hC0FFEE, 24'h0BADF0};
    audio_valid_in = 1'b1;
    tick();
    audio_valid_in = 1'b0;
    tick();
    tick();
    check("post_fs_c4", frame_start_out, 1'b1);
    check("post_ur_c4", underrun_out, 1'b0);
    wait_frames(10);
    check("frame9_g", frames[9], F_G);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
